fifo_thresh: RTL and testbench
==============================

FIFO_THRESH -- requirements
Module: fifo_thresh

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, entry count; power of two, >= 4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4; almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 4; almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have port clk, input, 1, sole clock; all state on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port push, input, 1, write request.
REQ-008 SHALL have port pop, input, 1, read request.
REQ-009 SHALL have port datain, input, WIDTH, write data.
REQ-010 SHALL have port dataout, output, WIDTH, show-ahead head-of-queue data.
REQ-011 SHALL have port count, output, CW = $clog2(DEPTH)+1, current occupancy.
REQ-012 SHALL have port full / empty, output, 1 each, count == DEPTH / count == 0.
REQ-013 SHALL have port almost_full / almost_empty, output, 1 each, threshold flags.
REQ-014 SHALL have port full_posedge / empty_posedge, output, 1 each, one-cycle rise pulses.
REQ-015 SHALL have port overflow / underflow, output, 1 each, sticky error flags.
REQ-016 SHALL have port err_clr, input, 1, synchronous clear of overflow/underflow.

Function
REQ-017 SHALL accept push when not full, or when full with pop asserted in the same cycle.
REQ-018 SHALL accept pop only when not empty; push+pop on empty accepts push only, and count becomes 1.
REQ-019 SHALL, on accepted push, write mem[wr_ptr] and increment wr_ptr modulo DEPTH.
REQ-020 SHALL, on accepted pop, increment rd_ptr modulo DEPTH; pointer wrap needs no special action.
REQ-021 SHALL update count registered: +1 on push only, -1 on pop only, unchanged when both or neither are accepted.
REQ-022 SHALL derive full, empty, almost_full and almost_empty combinationally from the registered count; zero added latency.
REQ-023 SHALL drive dataout = mem[rd_ptr] combinationally; the value is undefined when empty.
REQ-024 SHALL give data pushed in cycle N on dataout in cycle N+1 when the FIFO was empty.
REQ-025 SHALL assert full_posedge for exactly one cycle when full goes 0->1; empty_posedge likewise for empty.
REQ-026 SHALL set overflow on a rejected push (full, no pop) and underflow on a rejected pop (empty); both hold until err_clr or rst.
REQ-027 SHALL give set priority over err_clr when both occur in the same cycle.
REQ-028 SHALL leave count, pointers and memory unchanged on a rejected request.

Reset
REQ-029 SHALL, on rst assertion, immediately clear the pointers, count, overflow, underflow and the full/empty history registers, without waiting for clk.
REQ-030 SHALL hold these outputs while rst is high: empty=1, almost_empty=1, full=0, almost_full=0, count=0, full_posedge=0, empty_posedge=0.
REQ-031 SHALL NOT reset the memory array; contents after reset are don't-care.
REQ-032 SHALL discard all stored data on rst mid-operation; the first push after release lands at address 0.

Configuration
REQ-033 SHALL, with FIFO_HWM_EN defined, add output hwm (CW bits): peak count since reset, updated each cycle as max(hwm, count); hwm clears on rst only.
REQ-034 SHALL, without FIFO_HWM_EN, omit the hwm port and its logic entirely.

Structure
REQ-035 SHALL place in shared package fifo_pkg: a function computing CW from DEPTH, and a typedef for the error-flag pair {overflow, underflow}.
REQ-036 SHALL instantiate a sub-module fifo_ptr for a modulo-DEPTH pointer with increment enable; one instance each for rd_ptr and wr_ptr.
REQ-037 SHALL keep the storage as a flop array inside fifo_thresh, with no RAM macro.

Verification
REQ-038 SHALL cover: reset, then 64 pushes of 0..63 -> count=64, full=1, full_posedge pulses once on the 64th-push +1 cycle, almost_full from count=60.
REQ-039 SHALL cover: 65th push while full -> overflow=1, count stays 64; err_clr -> overflow=0 next cycle.
REQ-040 SHALL cover: 64 pops after fill -> dataout sequence 0..63, empty_posedge pulses once, almost_empty from count=4.
REQ-041 SHALL cover: push+pop every cycle at count=64 and at count=0 -> count unchanged at 64 / becomes 1, no error flags set.
REQ-042 SHALL cover: 100 push/pop pairs so both pointers wrap -> data order preserved, count constant.
REQ-043 SHALL cover: rst asserted mid-cycle at count=37 -> outputs per REQ-030 before next clk edge; with FIFO_HWM_EN, hwm=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared definitions for the fifo_thresh slice.
//   calc_cw     : occupancy counter width for a given depth ($clog2(DEPTH)+1,
//                 so the counter can hold the value DEPTH itself).
//   err_flags_t : the sticky error-flag pair {overflow, underflow}.
package fifo_pkg;

    function automatic int calc_cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr -- modulo-DEPTH pointer with increment enable.
// DEPTH is a power of two, so natural binary rollover is the modulo wrap.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears the pointer to 0
//   i_inc : advance the pointer by one this cycle
//   o_ptr : current pointer value
module fifo_ptr #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_inc,
    output logic [$clog2(DEPTH)-1:0] o_ptr
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + AW'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_thresh.sv
// fifo_thresh -- synchronous show-ahead FIFO with threshold flags, full/empty
// rise pulses and sticky overflow/underflow error flags.
// Optional feature macro: FIFO_HWM_EN adds the hwm (high-water mark) output.
// Ports:
//   clk, rst                    : clock (rising edge), async active-high reset
//   push, datain                : write request and data
//   pop                         : read request
//   dataout                     : head-of-queue data (undefined when empty)
//   count                       : occupancy, CW bits
//   full, empty                 : count == DEPTH / count == 0
//   almost_full, almost_empty   : count >= AF_LEVEL / count <= AE_LEVEL
//   full_posedge, empty_posedge : one-cycle pulses on full/empty rising
//   overflow, underflow         : sticky error flags, cleared by err_clr
//   err_clr                     : synchronous clear of the error flags
//   hwm (FIFO_HWM_EN only)      : peak count since reset
module fifo_thresh
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 64,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       datain,
    output logic [WIDTH-1:0]       dataout,
    output logic [calc_cw(DEPTH)-1:0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   full_posedge,
    output logic                   empty_posedge,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   err_clr
`ifdef FIFO_HWM_EN
    ,
    output logic [calc_cw(DEPTH)-1:0] hwm
`endif
);

    localparam int CW = calc_cw(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_full_d;
    logic             r_empty_d;
    err_flags_t       r_err;

    logic [AW-1:0]    w_wr_ptr;
    logic [AW-1:0]    w_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;
    err_flags_t       w_err_set;

    assign full         = (r_count == CW'(DEPTH));
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= CW'(AF_LEVEL));
    assign almost_empty = (r_count <= CW'(AE_LEVEL));
    assign count        = r_count;

    // A pop frees the slot a simultaneous push needs, so push is accepted
    // while full as long as pop is also asserted.
    assign w_push_ok = push && (!full || pop);
    assign w_pop_ok  = pop && !empty;

    // Push+pop on an empty FIFO is a valid streaming request: the push is
    // taken and the pop is simply not acted on, so it does not flag underflow.
    // Overflow is symmetric: push while full is only an error without pop.
    assign w_err_set.overflow  = push && full && !pop;
    assign w_err_set.underflow = pop && empty && !push;

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_push_ok),
        .o_ptr (w_wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_pop_ok),
        .o_ptr (w_rd_ptr)
    );

    // Storage is not reset; stale contents are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_ptr] <= datain;
        end
    end

    assign dataout = r_mem[w_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The empty history resets to 1 to match empty during reset, so no
    // spurious empty_posedge appears on reset or its release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full_d  <= 1'b0;
            r_empty_d <= 1'b1;
        end else begin
            r_full_d  <= full;
            r_empty_d <= empty;
        end
    end

    assign full_posedge  = full && !r_full_d;
    assign empty_posedge = empty && !r_empty_d;

    // A new error event wins over err_clr in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            if (err_clr) begin
                r_err <= '0;
            end
            if (w_err_set.overflow) begin
                r_err.overflow <= 1'b1;
            end
            if (w_err_set.underflow) begin
                r_err.underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_err.overflow;
    assign underflow = r_err.underflow;

`ifdef FIFO_HWM_EN
    logic [CW-1:0] r_hwm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hwm <= '0;
        end else if (r_count > r_hwm) begin
            r_hwm <= r_count;
        end
    end

    assign hwm = r_hwm;
`endif

endmodule

// File: tb/tb_fifo_thresh.sv
module tb_fifo_thresh;

    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int AF    = DEPTH - 4;
    localparam int AE    = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] datain;
    logic [WIDTH-1:0] dataout;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             full_posedge;
    logic             empty_posedge;
    logic             overflow;
    logic             underflow;
    logic             err_clr;
`ifdef FIFO_HWM_EN
    logic [CW-1:0]    hwm;
`endif

    fifo_thresh #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .pop           (pop),
        .datain        (datain),
        .dataout       (dataout),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .full_posedge  (full_posedge),
        .empty_posedge (empty_posedge),
        .overflow      (overflow),
        .underflow     (underflow),
        .err_clr       (err_clr)
`ifdef FIFO_HWM_EN
        ,
        .hwm           (hwm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a plain queue plus flags.
    logic [WIDTH-1:0] q[$];
    logic m_ov, m_un, m_fpe, m_epe;
    int   m_hwm;

    typedef struct {
        logic             p;
        logic             o;
        logic [WIDTH-1:0] d;
        logic             c;
        int               exp_count;
        logic             exp_empty;
        logic [WIDTH-1:0] exp_dout;
        logic             exp_un;
        logic             exp_epe;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ov  = 1'b0;
        m_un  = 1'b0;
        m_fpe = 1'b0;
        m_epe = 1'b0;
        m_hwm = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".afull"}, 32'(almost_full), 32'(q.size() >= AF));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(q.size() <= AE));
        chk({tag, ".fpe"}, 32'(full_posedge), 32'(m_fpe));
        chk({tag, ".epe"}, 32'(empty_posedge), 32'(m_epe));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ov));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_un));
        if (q.size() != 0) chk({tag, ".dout"}, 32'(dataout), 32'(q[0]));
`ifdef FIFO_HWM_EN
        chk({tag, ".hwm"}, 32'(hwm), 32'(m_hwm));
`endif
    endtask

    // One clock cycle: apply inputs, advance the model by the spec rules,
    // sample 1 ns after the rising edge.
    task automatic cyc(input logic p, input logic o, input logic [WIDTH-1:0] d,
                       input logic c, input string tag);
        bit was_full, was_empty, acc_push, acc_pop;
        push = p; pop = o; datain = d; err_clr = c;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        acc_push  = p && (!was_full || o);
        acc_pop   = o && !was_empty;
        @(posedge clk);
        #1;
        if (q.size() > m_hwm) m_hwm = q.size();
        if (acc_pop) void'(q.pop_front());
        if (acc_push) q.push_back(d);
        if (c) begin
            m_ov = 1'b0;
            m_un = 1'b0;
        end
        if (p && was_full && !o) m_ov = 1'b1;
        if (o && was_empty && !p) m_un = 1'b1;
        m_fpe = (q.size() == DEPTH) && !was_full;
        m_epe = (q.size() == 0) && !was_empty;
        check_all(tag);
    endtask

    task automatic do_reset();
        push = 0; pop = 0; datain = '0; err_clr = 0;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rst_hold");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_all("rst_rel");
    endtask

    initial begin
        int fpe_cnt, epe_cnt, af_at, ae_at;

        rst = 1'b1;
        push = 0; pop = 0; datain = '0; err_clr = 0;
        model_reset();

        // Hand-computed vectors from reset (count, empty, head, underflow, empty pulse).
        vecs[0] = '{1, 0, 8'h11, 0, 1, 0, 8'h11, 0, 0};
        vecs[1] = '{1, 0, 8'h22, 0, 2, 0, 8'h11, 0, 0};
        vecs[2] = '{0, 1, 8'h00, 0, 1, 0, 8'h22, 0, 0};
        vecs[3] = '{1, 1, 8'h33, 0, 1, 0, 8'h33, 0, 0};
        vecs[4] = '{0, 1, 8'h00, 0, 0, 1, 8'h00, 0, 1};
        vecs[5] = '{0, 1, 8'h00, 0, 0, 1, 8'h00, 1, 0};
        vecs[6] = '{0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 0};
        vecs[7] = '{1, 1, 8'h44, 0, 1, 0, 8'h44, 0, 0};
        vecs[8] = '{0, 1, 8'h00, 1, 0, 1, 8'h00, 0, 1};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].p, vecs[i].o, vecs[i].d, vecs[i].c, "vec");
            chk("vec.count", 32'(count), 32'(vecs[i].exp_count));
            chk("vec.empty", 32'(empty), 32'(vecs[i].exp_empty));
            chk("vec.unf", 32'(underflow), 32'(vecs[i].exp_un));
            chk("vec.epe", 32'(empty_posedge), 32'(vecs[i].exp_epe));
            if (!vecs[i].exp_empty) chk("vec.dout", 32'(dataout), 32'(vecs[i].exp_dout));
        end

        // Fill 0..63: full pulse once, almost_full first seen at 60.
        do_reset();
        fpe_cnt = 0;
        af_at = -1;
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, 0, 8'(i), 0, "fill");
            if (full_posedge) fpe_cnt++;
            if (almost_full && af_at < 0) af_at = int'(count);
        end
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.count", 32'(count), 32'd64);
        cyc(0, 0, 8'h00, 0, "fill_idle");
        if (full_posedge) fpe_cnt++;
        chk("fill.fpe_once", 32'(fpe_cnt), 32'd1);
        chk("fill.af_at", 32'(af_at), 32'd60);

        // Overflow and its clear.
        cyc(1, 0, 8'hEE, 0, "ovf");
        chk("ovf.set", 32'(overflow), 32'd1);
        chk("ovf.count", 32'(count), 32'd64);
        cyc(0, 0, 8'h00, 1, "ovf_clr");
        chk("ovf.clr", 32'(overflow), 32'd0);

        // Drain: head sequence 0..63, empty pulse once, almost_empty first at 4.
        epe_cnt = 0;
        ae_at = -1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain.seq", 32'(dataout), 32'(i));
            cyc(0, 1, 8'h00, 0, "drain");
            if (empty_posedge) epe_cnt++;
            if (almost_empty && ae_at < 0) ae_at = int'(count);
        end
        cyc(0, 0, 8'h00, 0, "drain_idle");
        if (empty_posedge) epe_cnt++;
        chk("drain.epe_once", 32'(epe_cnt), 32'd1);
        chk("drain.ae_at", 32'(ae_at), 32'd4);

        // Push+pop on empty: push taken, count 1, no underflow.
        cyc(1, 1, 8'hA5, 0, "pp_empty");
        chk("pp_empty.count", 32'(count), 32'd1);
        chk("pp_empty.unf", 32'(underflow), 32'd0);
        chk("pp_empty.dout", 32'(dataout), 32'hA5);

        // Refill to full then push+pop at full.
        for (int i = 1; i < DEPTH; i++) cyc(1, 0, 8'(8'h80 + i), 0, "refill");
        for (int i = 0; i < 8; i++) cyc(1, 1, 8'(8'hC0 + i), 0, "pp_full");
        chk("pp_full.count", 32'(count), 32'd64);
        chk("pp_full.ovf", 32'(overflow), 32'd0);
        chk("pp_full.unf", 32'(underflow), 32'd0);

        // 100 push/pop pairs at count 10 so both pointers wrap.
        while (q.size() > 10) cyc(0, 1, 8'h00, 0, "to10");
        for (int i = 0; i < 100; i++) cyc(1, 1, 8'(i * 7 + 3), 0, "wrap");
        chk("wrap.count", 32'(count), 32'd10);

        // Random traffic with phases biased towards full and empty.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 400) % 2 == 0) ? 75 : 25;
            cyc($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
                8'($urandom), $urandom_range(0, 99) < 5, "rand");
        end

        // Asynchronous reset mid-cycle at count 37.
        do_reset();
        for (int i = 0; i < 37; i++) cyc(1, 0, 8'(i + 100), 0, "to37");
        chk("mid.count37", 32'(count), 32'd37);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("mid_rst");
        chk("mid.empty", 32'(empty), 32'd1);
        chk("mid.count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 0, 8'h5A, 0, "post_rst");
        chk("post_rst.dout", 32'(dataout), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
